sraml_arbiter: RTL and testbench

- Two-master to one-slave arbiter on the sram_like bus.
- Sits between the inst/data sram-to-sram_like bridges and a single sram_like port of the AXI interface, so one shared sram_like channel serves both fetch and memory stages.
- Tracks outstanding transactions in an owner FIFO and routes each data_ok/rdata back to the master that issued it, in issue order.

---
 rtl/sraml_pkg.sv | 24 ++
 rtl/sraml_owner_fifo.sv | 61 ++++++
 rtl/sraml_arbiter.sv | 127 ++++++++++++
 tb/tb_sraml_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sraml_pkg.sv
// ============================================================================
// sraml_pkg : shared owner tags, grant states and size codes for the arbiter
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sraml_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } grant_st_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sraml_owner_fifo.sv
// ============================================================================
// sraml_owner_fifo : tag FIFO remembering which master owns each outstanding
//                    transaction, head = owner of the next response
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sraml_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [TAG_W-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: head is only consulted while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= tag_i;
    end

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/sraml_arbiter.sv
// ============================================================================
// sraml_arbiter : two-master (inst/data) to one-slave sram_like arbiter with
//                 in-order response routing. SRAML_ARB_RR_EN: round-robin.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sraml_arbiter
    import sraml_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int OWN_W       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err
);

    grant_st_e        state_q;
    logic             err_q;
    logic             w_pick_data;
    logic             w_grant_data;
    logic             w_g_req;
    logic             w_hs;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [OWN_W-1:0] w_head;

`ifdef SRAML_ARB_RR_EN
    logic last_q;

    // On a tie, favour whichever master did not win the previous handshake.
    assign w_pick_data = data_req & (~inst_req | (last_q == OWN_INST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_q <= OWN_INST;
        else if (w_hs) last_q <= w_grant_data;
    end
`else
    assign w_pick_data = data_req;
`endif

    assign w_grant_data = (state_q == ST_LOCK_D) | ((state_q == ST_IDLE) & w_pick_data);
    assign w_g_req      = w_grant_data ? data_req : inst_req;
    assign w_hs         = s_req & s_addr_ok;
    assign w_pop        = s_data_ok & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_g_req && !w_hs)
                        state_q <= w_grant_data ? ST_LOCK_D : ST_LOCK_I;
                end
                ST_LOCK_I, ST_LOCK_D: begin
                    if (w_hs) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        err_q <= 1'b0;
        else if (s_data_ok && w_empty)  err_q <= 1'b1;
    end

    sraml_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .TAG_W (OWN_W)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_hs),
        .tag_i   (OWN_W'(w_grant_data)),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    assign s_req   = w_g_req & ~w_full;
    assign s_wr    = w_grant_data ? data_wr    : inst_wr;
    assign s_size  = w_grant_data ? data_size  : inst_size;
    assign s_addr  = w_grant_data ? data_addr  : inst_addr;
    assign s_wdata = w_grant_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = w_hs & ~w_grant_data;
    assign data_addr_ok = w_hs &  w_grant_data;

    assign inst_data_ok = w_pop & (w_head == OWN_W'(OWN_INST));
    assign data_data_ok = w_pop & (w_head == OWN_W'(OWN_DATA));
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;

    assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sraml_arbiter.sv
// ============================================================================
// tb_sraml_arbiter : self-checking bench for sraml_arbiter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sraml_arbiter;

    localparam int OUTST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = '0, inst_wdata = '0, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = '0;
    logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: queue of issuing masters (0 = inst, 1 = data) in issue order.
    int own_q[$];
    int locked = -1;
    bit err_e  = 1'b0;
    int last_w = 0;
    int win_e  = 0;
    bit hs_e   = 1'b0;
    bit pop_e  = 1'b0;

    always #5 clk = ~clk;

    sraml_arbiter #(.OUTSTANDING(OUTST), .OWN_W(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .s_req        (s_req),
        .s_wr         (s_wr),
        .s_size       (s_size),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_rdata      (s_rdata),
        .s_addr_ok    (s_addr_ok),
        .s_data_ok    (s_data_ok),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for the inputs currently applied, from the arbitration rules.
    task automatic model_check();
        bit wreq;
        bit full;
        bit head_is_data;
        if (locked >= 0) begin
            win_e = locked;
        end else begin
`ifdef SRAML_ARB_RR_EN
            if (inst_req && data_req) win_e = (last_w == 0) ? 1 : 0;
            else                      win_e = data_req ? 1 : 0;
`else
            win_e = data_req ? 1 : 0;
`endif
        end
        wreq  = (win_e == 1) ? data_req : inst_req;
        full  = (own_q.size() >= OUTST);
        hs_e  = wreq && !full && s_addr_ok;
        pop_e = s_data_ok && (own_q.size() > 0);
        head_is_data = pop_e ? (own_q[0] == 1) : 1'b0;

        chk("s_req", s_req, wreq && !full);
        if (wreq && !full) begin
            chk("s_addr",  s_addr,  (win_e == 1) ? data_addr  : inst_addr);
            chk("s_wr",    s_wr,    (win_e == 1) ? data_wr    : inst_wr);
            chk("s_size",  s_size,  (win_e == 1) ? data_size  : inst_size);
            chk("s_wdata", s_wdata, (win_e == 1) ? data_wdata : inst_wdata);
        end
        chk("inst_addr_ok", inst_addr_ok, hs_e && (win_e == 0));
        chk("data_addr_ok", data_addr_ok, hs_e && (win_e == 1));
        chk("inst_data_ok", inst_data_ok, pop_e && !head_is_data);
        chk("data_data_ok", data_data_ok, pop_e && head_is_data);
        if (pop_e) begin
            chk("inst_rdata", inst_rdata, s_rdata);
            chk("data_rdata", data_rdata, s_rdata);
        end
        chk("err", err, err_e);
    endtask

    task automatic clk_adv();
        bit wreq;
        @(posedge clk);
        wreq = (win_e == 1) ? data_req : inst_req;
        if (s_data_ok && own_q.size() == 0) err_e = 1'b1;
        if (pop_e) void'(own_q.pop_front());
        if (hs_e) begin
            own_q.push_back(win_e);
            last_w = win_e;
            locked = -1;
        end else begin
            locked = wreq ? win_e : -1;
        end
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
        clk_adv();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        inst_req  = 1'b0;
        data_req  = 1'b0;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        #1;
        chk("rst_s_req",        s_req,        1'b0);
        chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk("rst_data_addr_ok", data_addr_ok, 1'b0);
        chk("rst_inst_data_ok", inst_data_ok, 1'b0);
        chk("rst_data_data_ok", data_data_ok, 1'b0);
        chk("rst_err",          err,          1'b0);
        own_q.delete();
        locked = -1;
        err_e  = 1'b0;
        last_w = 0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
    endtask

    task automatic drain();
        inst_req  = 1'b0;
        data_req  = 1'b0;
        s_addr_ok = 1'b0;
        for (int i = 0; i < 20 && own_q.size() > 0; i++) begin
            s_data_ok = 1'b1;
            s_rdata   = $urandom;
            cyc();
        end
        s_data_ok = 1'b0;
    endtask

    task automatic settle_reqs();
        for (int i = 0; i < 20 && (inst_req || data_req); i++) begin
            s_addr_ok = 1'b1;
            s_data_ok = (own_q.size() > 0);
            s_rdata   = $urandom;
            cyc();
            if (hs_e && win_e == 0) inst_req = 1'b0;
            if (hs_e && win_e == 1) data_req = 1'b0;
        end
        chk("settle_timeout", {inst_req, data_req}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Simultaneous requests: data first, then inst; responses routed in order.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_wr = 1'b0; inst_size = 2'd2;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_wr = 1'b0; data_size = 2'd2;
        s_addr_ok = 1'b1;
        @(negedge clk); model_check(); chk("simul_first", s_addr, 32'h8000_1000); clk_adv();
        data_req = 1'b0;
        @(negedge clk); model_check(); chk("simul_second", s_addr, 32'hBFC0_0000); clk_adv();
        inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h1111_2222;
        @(negedge clk); model_check(); chk("route_data_first", data_data_ok, 1'b1); clk_adv();
        s_rdata = 32'h3333_4444;
        @(negedge clk); model_check(); chk("route_inst_second", inst_data_ok, 1'b1); clk_adv();
        s_data_ok = 1'b0;

        // Lock: inst grant held while data arrives, then data served.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        cyc();
        data_req = 1'b1; data_addr = 32'h8000_2000;
        @(negedge clk); model_check(); chk("lock_hold1", s_addr, 32'hBFC0_0000); clk_adv();
        @(negedge clk); model_check(); chk("lock_hold2", s_addr, 32'hBFC0_0000); clk_adv();
        s_addr_ok = 1'b1;
        @(negedge clk); model_check(); chk("lock_accept", inst_addr_ok, 1'b1); clk_adv();
        inst_req = 1'b0;
        @(negedge clk); model_check(); chk("lock_then_data", data_addr_ok, 1'b1); clk_adv();
        data_req = 1'b0;
        drain();

        // Full: no acceptance while full, and no same-cycle bypass on a pop.
        inst_req = 1'b1; inst_addr = 32'h0000_00A0; s_addr_ok = 1'b1;
        cyc();
        inst_addr = 32'h0000_00A4;
        cyc();
        inst_addr = 32'h0000_00A8;
        @(negedge clk); model_check(); chk("full_block", s_req, 1'b0); clk_adv();
        s_data_ok = 1'b1;
        @(negedge clk); model_check(); chk("full_no_bypass", s_req, 1'b0); clk_adv();
        s_data_ok = 1'b0;
        @(negedge clk); model_check(); chk("full_release", s_req, 1'b1); clk_adv();
        inst_req = 1'b0;
        drain();

        // Randomized traffic with concurrent push/pop and pointer wrap.
        for (int n = 0; n < 2000; n++) begin
            if (!inst_req && ($urandom % 2 == 0)) begin
                inst_req = 1'b1; inst_addr = $urandom; inst_wr = $urandom % 2;
                inst_size = 2'($urandom % 3); inst_wdata = $urandom;
            end
            if (!data_req && ($urandom % 2 == 0)) begin
                data_req = 1'b1; data_addr = $urandom; data_wr = $urandom % 2;
                data_size = 2'($urandom % 3); data_wdata = $urandom;
            end
            s_addr_ok = ($urandom % 3 != 0);
            s_data_ok = (own_q.size() > 0) && ($urandom % 2 == 0);
            s_rdata   = $urandom;
            cyc();
            if (hs_e && win_e == 0) inst_req = 1'b0;
            if (hs_e && win_e == 1) data_req = 1'b0;
        end
        settle_reqs();
        drain();

        // Protocol error: response with nothing outstanding.
        s_data_ok = 1'b1;
        @(negedge clk); model_check(); chk("err_no_dok", inst_data_ok | data_data_ok, 1'b0); clk_adv();
        s_data_ok = 1'b0;
        @(negedge clk); model_check(); chk("err_set", err, 1'b1); clk_adv();
        cyc();
        cyc();

        // Reset with a transaction outstanding; late response afterwards is an error.
        inst_req = 1'b1; inst_addr = 32'h0000_0100; s_addr_ok = 1'b1;
        cyc();
        inst_req = 1'b0; s_addr_ok = 1'b0;
        do_reset();
        s_data_ok = 1'b1;
        cyc();
        s_data_ok = 1'b0;
        @(negedge clk); model_check(); chk("late_dok_err", err, 1'b1); clk_adv();
        cyc();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
